// File: rtl/stream_framer_pkg.sv
// stream_framer_pkg: shared sample type, FSM states and buffer sizing for the stream framer.
package stream_framer_pkg;
    typedef logic [31:0] float_24_8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int FLOAT_W    = $bits(float_24_8);
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/stream_framer_if.sv
// stream_framer_if: upstream and downstream valid/ready streams of the framer.
interface stream_framer_if import stream_framer_pkg::*; #(
    parameter int WIDTH = FLOAT_W
);
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_fst;
    logic             out_vld;
    logic             out_rdy;
    modport master (output in_data, in_vld, out_rdy, input in_rdy, out_data, out_fst, out_vld);
    modport slave  (input in_data, in_vld, out_rdy, output in_rdy, out_data, out_fst, out_vld);
endinterface

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: two-entry buffer with registered occupancy; head reads as zero when empty.
module stream_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp, rp;

    assign dout = count != '0 ? mem[rp] : '0;

    always_ff @(posedge clk)
        if (push) mem[wp] <= din;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= '0;
        end else if (flush) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= '0;
        end else begin
            wp    <= wp ^ push;
            rp    <= rp ^ pop;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/stream_framer.sv
// stream_framer: cuts an input stream into frames, tagging the first word of each,
// and stops after num_frames frames (0 = run until aborted).
module stream_framer import stream_framer_pkg::*; #(
    parameter int WIDTH = FLOAT_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           abort,
    input  logic [15:0]    frame_length,
    input  logic [31:0]    num_frames,
    stream_framer_if.slave s,
    output logic [31:0]    frame_count,
    output logic           load_finish
);
    state_t       state, state_nx;
    logic [15:0]  len, idx;
    logic [31:0]  nfr;
    logic [1:0]   count;
    logic [WIDTH:0] head;
    logic         accept, pop, last_word, last_frame, start;

    // ready depends only on registered state so out_rdy never reaches in_rdy
    assign s.in_rdy    = state == RUN && count < 2'(DEPTH);
    assign accept      = s.in_vld && s.in_rdy;
    assign pop         = s.out_vld && s.out_rdy;
    assign last_word   = idx == len - 16'd1;
    assign last_frame  = accept && last_word && nfr != '0 && frame_count == nfr - 32'd1;
    assign start       = state == IDLE && enable && !abort;
    assign s.out_vld   = count != '0;
    assign {s.out_fst, s.out_data} = head;
    assign load_finish = state == DRAIN && count == '0 && !abort;

    always_comb begin
        state_nx = state;
        if (abort) state_nx = IDLE;
        else if (start) state_nx = RUN;
        else if (state == RUN && last_frame) state_nx = DRAIN;
        else if (load_finish) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            len         <= 16'd1;
            nfr         <= '0;
            idx         <= '0;
            frame_count <= '0;
        end else if (abort) begin
            idx <= '0;
        end else if (start) begin
            len         <= frame_length == '0 ? 16'd1 : frame_length;
            nfr         <= num_frames;
            idx         <= '0;
            frame_count <= '0;
        end else if (accept) begin
            idx <= last_word ? '0 : idx + 16'd1;
            if (last_word && frame_count != '1) frame_count <= frame_count + 32'd1;
        end

    stream_skid_fifo #(.W(WIDTH + 1)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (abort),
        .push  (accept),
        .pop   (pop),
        .din   ({idx == '0, s.in_data}),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: directed checks of framing, back-pressure, abort and reset behaviour.
module tb_stream_framer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] frame_length = '0;
    logic [31:0] num_frames = '0;
    logic [31:0] frame_count;
    logic        load_finish;

    always #5 clk = ~clk;

    stream_framer_if #(.WIDTH(32)) bus ();

    stream_framer #(.WIDTH(32), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .abort        (abort),
        .frame_length (frame_length),
        .num_frames   (num_frames),
        .s            (bus.slave),
        .frame_count  (frame_count),
        .load_finish  (load_finish)
    );

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, acc_total = 0, lf_cnt = 0, lf_cyc = -1;
    int          first_acc = -1, first_pop = -1, last_pop = -1;
    logic [31:0] q_data[$];
    logic        q_fst[$];
    bit          fc_mono = 1'b1;
    logic [31:0] fc_prev = '0;
    logic [31:0] held, d0;
    int          bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        q_data.delete();
        q_fst.delete();
        acc_total = 0;
        lf_cnt    = 0;
        lf_cyc    = -1;
        first_acc = -1;
        first_pop = -1;
        last_pop  = -1;
    endtask

    // sample at the falling edge, advance the source word after an accepting rising edge
    task automatic cycles(input int n);
        bit acc;
        repeat (n) begin
            @(negedge clk);
            acc = bus.in_vld && bus.in_rdy;
            if (acc) begin
                acc_total++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (bus.out_vld && bus.out_rdy) begin
                q_data.push_back(bus.out_data);
                q_fst.push_back(bus.out_fst);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (load_finish) begin
                lf_cnt++;
                lf_cyc = cyc;
            end
            if (frame_count < fc_prev) fc_mono = 1'b0;
            fc_prev = frame_count;
            cyc++;
            @(posedge clk);
            #1;
            if (acc) bus.in_data = bus.in_data + 32'd1;
        end
    endtask

    task automatic start(input logic [15:0] len, input logic [31:0] nf);
        frame_length = len;
        num_frames   = nf;
        enable       = 1'b1;
        cycles(1);
        enable = 1'b0;
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_vld  = 1'b1;
        bus.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", bus.in_rdy, 0);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_fst", bus.out_fst, 0);
        check("rst_load_finish", load_finish, 0);
        check("rst_frame_count", frame_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 3 frames of 4 words, free flowing
        clear();
        bus.in_data = 32'd100;
        start(16'd4, 32'd3);
        cycles(20);
        check("t1_words", q_data.size(), 12);
        bad = 0;
        foreach (q_data[i]) if (q_data[i] !== 32'(100 + i) || q_fst[i] !== (i % 4 == 0)) bad++;
        check("t1_data_fst", bad, 0);
        check("t1_frame_count", frame_count, 3);
        check("t1_lf_cnt", lf_cnt, 1);
        check("t1_lf_after_last", lf_cyc, last_pop + 1);
        check("t1_latency", first_pop, first_acc + 1);
        check("t1_throughput", last_pop - first_pop, 11);
        check("t1_idle_rdy", bus.in_rdy, 0);

        // downstream stall for 5 cycles mid-frame
        clear();
        bus.in_data = 32'd0;
        start(16'd8, 32'd1);
        cycles(2);
        bus.out_rdy = 1'b0;
        cycles(1);
        held = bus.out_data;
        cycles(4);
        check("t2_in_rdy_full", bus.in_rdy, 0);
        check("t2_out_vld", bus.out_vld, 1);
        check("t2_held_val", bus.out_data, 1);
        check("t2_held_stable", bus.out_data, held);
        check("t2_buffered", acc_total, q_data.size() + 2);
        bus.out_rdy = 1'b1;
        cycles(15);
        check("t2_words", q_data.size(), 8);
        bad = 0;
        foreach (q_data[i]) if (q_data[i] !== 32'(i) || q_fst[i] !== (i == 0)) bad++;
        check("t2_seq", bad, 0);
        check("t2_lf_cnt", lf_cnt, 1);

        // zero length behaves as one-word frames
        clear();
        bus.in_data = 32'h200;
        start(16'd0, 32'd2);
        cycles(8);
        check("t3_words", q_data.size(), 2);
        check("t3_fst", {q_fst[0], q_fst[1]}, 2'b11);
        check("t3_data1", q_data[1], 32'h201);
        check("t3_frame_count", frame_count, 2);
        check("t3_lf_cnt", lf_cnt, 1);

        // abort outranks enable in IDLE
        enable = 1'b1;
        abort  = 1'b1;
        cycles(1);
        enable = 1'b0;
        abort  = 1'b0;
        check("t4_abort_prio", bus.in_rdy, 0);

        // abort at word 2 of the second frame
        clear();
        bus.in_data = 32'd0;
        start(16'd4, 32'd3);
        cycles(6);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("t4_out_vld", bus.out_vld, 0);
        check("t4_in_rdy", bus.in_rdy, 0);
        check("t4_fc_hold", frame_count, 1);
        cycles(3);
        check("t4_no_lf", lf_cnt, 0);
        clear();
        d0 = bus.in_data;
        start(16'd4, 32'd1);
        cycles(8);
        check("t4_rerun_words", q_data.size(), 4);
        check("t4_rerun_fst", q_fst[0], 1);
        check("t4_rerun_data", q_data[0], d0);
        check("t4_rerun_lf", lf_cnt, 1);

        // unbounded run of 36-word frames
        clear();
        bus.in_data = 32'd0;
        start(16'd36, 32'd0);
        fc_mono = 1'b1;
        fc_prev = '0;
        cycles(36864);
        check("t5_no_lf", lf_cnt, 0);
        check("t5_still_run", bus.in_rdy, 1);
        check("t5_fc_range", frame_count == 32'd1023 || frame_count == 32'd1024, 1);
        check("t5_fc_mono", fc_mono, 1);
        bad = 0;
        foreach (q_data[i]) if (q_data[i] !== 32'(i) || q_fst[i] !== (i % 36 == 0)) bad++;
        check("t5_seq_fst", bad, 0);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;

        // asynchronous reset mid-burst
        clear();
        bus.in_data = 32'h300;
        start(16'd4, 32'd0);
        cycles(5);
        #2;
        reset = 1'b0;
        #1;
        check("t6_out_vld", bus.out_vld, 0);
        check("t6_in_rdy", bus.in_rdy, 0);
        check("t6_out_data", bus.out_data, 0);
        check("t6_out_fst", bus.out_fst, 0);
        check("t6_lf", load_finish, 0);
        check("t6_fc", frame_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear();
        d0 = bus.in_data;
        start(16'd4, 32'd1);
        cycles(8);
        check("t6_restart_fst", q_fst[0], 1);
        check("t6_restart_data", q_data[0], d0);
        check("t6_restart_words", q_data.size(), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
